sample_elastic_pipe: RTL and testbench
======================================

// Module: sample_elastic_pipe
//
// PURPOSE
//   Parametrised successor to the fixed-depth, valid-only sample pipeline.
//   Carries a WIDTH-bit payload through STAGES register stages with full
//   ready/valid backpressure and bubble collapsing.
//   Data registers are either unreset (load-enable gated) or reset, chosen at
//   elaboration time.
//   Sits between an XLS-generated compute block and a downstream consumer
//   that may stall; also reports how many stages currently hold data.
//
// PARAMETERS
//   STAGES      default 2    number of register stages, >= 1; sets latency
//   WIDTH       default 32   payload width in bits, >= 1
//   DATA_RESET  default 0    0: data regs have no reset and load only on
//                            accept; 1: data regs async-reset to RESET_VALUE
//   RESET_VALUE default '0   data reset value, used only when DATA_RESET=1
//
// PORTS
//   clk        in   1                 sole clock, rising edge
//   rst_n      in   1                 asynchronous reset, active low
//   flush      in   1                 synchronous: drop all in-flight data
//   in_valid   in   1                 upstream payload valid
//   in_ready   out  1                 stage 0 can accept this cycle
//   in_data    in   WIDTH             upstream payload
//   out_valid  out  1                 last stage holds valid data
//   out_ready  in   1                 downstream accepts this cycle
//   out_data   out  WIDTH             last-stage payload
//   occupancy  out  $clog2(STAGES+1)  count of valid stages, 0..STAGES
//
// BEHAVIOUR
//   - Reset, while rst_n=0 (asynchronous assert, synchronous deassert by
//     integration):
//     - all stage valid bits=0, so out_valid=0 and occupancy=0
//     - in_ready=1 (pure function of the valid bits)
//     - DATA_RESET=1: every data reg and out_data=RESET_VALUE
//     - DATA_RESET=0: data regs X until first load; out_data is don't-care
//       while out_valid=0
//   - Per-stage advance, stage i, last=STAGES-1:
//     - adv[last] = v[last] & out_ready
//     - adv[i]    = v[i] & (~v[i+1] | adv[i+1])
//   - in_ready = ~v[0] | adv[0]. This is a combinational ripple through all
//     stages; a bubble anywhere lets upstream advance (bubble collapse).
//   - Stage load enables:
//     - ld[0] = in_valid & in_ready
//     - ld[i] = adv[i-1]
//     - data[i] <= ld[i] ? src : data[i]; no reset term in ld
//   - Valid update: v[i] <= ld[i] | (v[i] & ~adv[i]).
//   - Latency STAGES cycles from accept to out_valid with no stalls;
//     throughput 1 beat/cycle with out_ready held high.
//   - Full (occupancy=STAGES) with out_ready=1: accepts and emits in the same
//     cycle; occupancy unchanged.
//   - Full with out_ready=0: in_ready=0; all data held stable; out_valid and
//     out_data hold (AXI-style, no retraction).
//   - Empty: out_valid=0, in_ready=1.
//   - occupancy = popcount(v), registered-equivalent (derived from regs,
//     not from inputs).
//   - flush=1:
//     - all v <= 0 next cycle
//     - in_ready forced 0 that cycle, so any in_valid beat is not accepted
//     - out_valid still reflects current regs; a beat transferred this cycle
//       counts as delivered
//     - data regs untouched
//   - rst_n asserted mid-transfer: in-flight beats are lost, no partial
//     output; outputs as under Reset.
//   - STAGES=1 degenerates to a single skid-free register slice with
//     combinational in_ready from out_ready.
//
// STRUCTURE
//   - sample_pipe_pkg:
//     - function occ_width(STAGES) = $clog2(STAGES+1)
//     - typedef enum {DATA_NORESET=0, DATA_RESETTABLE=1} for DATA_RESET
//   - Sub-module sample_pipe_stage (WIDTH, DATA_RESET, RESET_VALUE):
//     - one valid bit plus data reg
//     - ports: ld, adv, flush, src data; outputs v, data
//     - top generates STAGES instances and the adv/ready chain
//   - Popcount for occupancy lives in the top level; no other state.
//
// TESTING
//   1. Reset: rst_n=0 mid-stream with 2 beats in flight -> same cycle
//      out_valid=0, occupancy=0, in_ready=1; DATA_RESET=1 -> out_data=0.
//   2. Latency, STAGES=3, WIDTH=32: out_ready=1, push 0x2A at cycle 0 ->
//      out_valid=1, out_data=0x2A at cycle 3 only.
//   3. Streaming: push 0x1..0x8 back-to-back, out_ready=1 -> outputs 0x1..0x8
//      on 8 consecutive cycles, in_ready never drops.
//   4. Stall/full, STAGES=3: out_ready=0, push 0xA,0xB,0xC,0xD -> 0xD not
//      accepted, occupancy=3, out_data=0xA stable; raise out_ready -> A,B,C
//      then D in order.
//   5. Bubble collapse: v={1,0,1} with out_ready=0 -> in_ready=1; stage 0
//      beat moves into the hole next cycle, occupancy 2->3 after push.
//   6. Flush with in_valid=1 at occupancy=2 -> beat not accepted, occupancy=0
//      next cycle, out_valid=0; subsequent push 0x55 emerges after STAGES
//      cycles.

Source files
------------

// File: rtl/sample_elastic_pipe_pkg.sv
// sample_pipe_pkg: shared types and helpers for the elastic sample pipeline
package sample_pipe_pkg;
  typedef enum logic {DATA_NORESET = 1'b0, DATA_RESETTABLE = 1'b1} data_reset_e;
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/sample_elastic_pipe_if.sv
// sample_elastic_pipe_if: upstream/downstream ready-valid bundle
//   slave  (pipe view): in_valid/in_data/out_ready in, in_ready/out_valid/out_data out
//   master (env view) : the mirror image
interface sample_elastic_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/sample_elastic_pipe_stage.sv
// sample_pipe_stage: one valid bit plus payload register
//   ld/adv/flush in -> v; src in -> data (optionally async-reset)
module sample_pipe_stage import sample_pipe_pkg::*; #(
  parameter int               WIDTH       = 32,
  parameter data_reset_e      DATA_RESET  = DATA_NORESET,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             adv,
  input  logic             flush,
  input  logic [WIDTH-1:0] src,
  output logic             v,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= 1'b0;
    else v <= ~flush & (ld | (v & ~adv));
  if (DATA_RESET == DATA_RESETTABLE) begin : g_rst
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) data <= RESET_VALUE;
      else if (ld) data <= src;
  end else begin : g_nrst
    always_ff @(posedge clk)
      if (ld) data <= src;
  end
endmodule

// File: rtl/sample_elastic_pipe.sv
// sample_elastic_pipe: STAGES-deep ready/valid pipe with bubble collapse
//   clk, rst_n (async, active low), flush (sync drop of in-flight data)
//   bus: slave side of sample_elastic_pipe_if; occupancy: valid-stage count
module sample_elastic_pipe import sample_pipe_pkg::*; #(
  parameter int               STAGES      = 2,
  parameter int               WIDTH       = 32,
  parameter data_reset_e      DATA_RESET  = DATA_NORESET,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  sample_elastic_pipe_if.slave           bus,
  output logic [occ_width(STAGES)-1:0]   occupancy
);
  localparam int OW = occ_width(STAGES);
  logic [STAGES-1:0] v, adv, ld;
  logic [WIDTH-1:0]  d [STAGES];
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic [WIDTH-1:0] src;
    // A stage advances when some later stage is empty (the hole absorbs the
    // shift) or when every later stage is full and the sink takes a beat;
    // this is the unrolled form of the stage-to-stage ready ripple.
    if (i == STAGES - 1) begin : g_last
      assign adv[i] = v[i] & bus.out_ready;
    end else begin : g_mid
      assign adv[i] = v[i] & (~&v[STAGES-1:i+1] | bus.out_ready);
    end
    if (i == 0) begin : g_head
      assign ld[i] = bus.in_valid & bus.in_ready;
      assign src   = bus.in_data;
    end else begin : g_body
      assign ld[i] = adv[i-1];
      assign src   = d[i-1];
    end
    sample_pipe_stage #(
      .WIDTH(WIDTH), .DATA_RESET(DATA_RESET), .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clk(clk), .rst_n(rst_n), .ld(ld[i]), .adv(adv[i]), .flush(flush),
      .src(src), .v(v[i]), .data(d[i])
    );
  end
  assign bus.in_ready  = ~flush & (~v[0] | adv[0]);
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_data  = d[STAGES-1];
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OW'(v[i]);
  end
endmodule

// File: tb/tb_sample_elastic_pipe.sv
// tb_sample_elastic_pipe: directed table plus randomized model check
module tb_sample_elastic_pipe;
  import sample_pipe_pkg::*;
  localparam int S = 3;
  typedef struct {
    logic iv; logic [31:0] d; logic o; logic f;
    logic ov; logic [31:0] od; logic ir; int occ;
  } vec_t;
  typedef struct {logic [31:0] d; int pos;} item_t;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [1:0] occ;
  logic [0:0] occ1;
  int total = 0, bad = 0;
  vec_t tbl[$];
  item_t q[$];
  int np[$];
  sample_elastic_pipe_if #(.WIDTH(32)) bus ();
  sample_elastic_pipe_if #(.WIDTH(32)) bus1 ();
  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.out_ready  = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;
  sample_elastic_pipe #(.STAGES(S), .WIDTH(32), .DATA_RESET(DATA_RESETTABLE), .RESET_VALUE('0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .occupancy(occ));
  sample_elastic_pipe #(.STAGES(1), .WIDTH(32), .DATA_RESET(DATA_NORESET), .RESET_VALUE('0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1), .occupancy(occ1));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic [31:0] d, input logic o, input logic f);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = o; flush = f;
    #1;
  endtask
  task automatic add(input logic iv, input logic [31:0] d, input logic o, input logic f,
                     input logic ov, input logic [31:0] od, input logic ir, input int oc);
    tbl.push_back('{iv, d, o, f, ov, od, ir, oc});
  endtask
  initial begin
    int p, n, prev;
    bit eir, eov, eir1, mv1;
    logic [31:0] md1;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    mv1 = 1'b0; md1 = '0;
    drive(0, 0, 0, 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_data", bus.out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    add(1, 'h2A, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1, 'h2A, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) add(1, k, 1, 0, k >= 4, k - 3, 1, k < 4 ? k - 1 : 3);
    for (int k = 9; k <= 11; k++) add(0, 0, 1, 0, 1, k - 3, 1, 12 - k);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 'hA, 0, 0, 0, 0, 1, 0);
    add(1, 'hB, 0, 0, 0, 0, 1, 1);
    add(1, 'hC, 0, 0, 0, 0, 1, 2);
    add(1, 'hD, 0, 0, 1, 'hA, 0, 3);
    add(0, 0, 0, 0, 1, 'hA, 0, 3);
    add(0, 0, 1, 0, 1, 'hA, 1, 3);
    add(0, 0, 1, 0, 1, 'hB, 1, 2);
    add(0, 0, 1, 0, 1, 'hC, 1, 1);
    add(1, 'hD, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1, 'hD, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 'hE, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'hF, 0, 0, 0, 0, 1, 1);
    add(1, 'h67, 0, 0, 1, 'hE, 1, 2);
    add(0, 0, 0, 0, 1, 'hE, 0, 3);
    add(0, 0, 1, 0, 1, 'hE, 1, 3);
    add(0, 0, 1, 0, 1, 'hF, 1, 2);
    add(0, 0, 1, 0, 1, 'h67, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 'h11, 0, 0, 0, 0, 1, 0);
    add(1, 'h22, 0, 0, 0, 0, 1, 1);
    add(1, 'h99, 0, 1, 0, 0, 0, 2);
    add(1, 'h55, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1, 'h55, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    foreach (tbl[r]) begin
      drive(tbl[r].iv, tbl[r].d, tbl[r].o, tbl[r].f);
      chk($sformatf("tbl%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].ov));
      chk($sformatf("tbl%0d_in_ready", r), 32'(bus.in_ready), 32'(tbl[r].ir));
      chk($sformatf("tbl%0d_occ", r), 32'(occ), 32'(tbl[r].occ));
      if (tbl[r].ov) chk($sformatf("tbl%0d_out_data", r), bus.out_data, tbl[r].od);
    end
    drive(1, 'h71, 1, 0);
    drive(1, 'h72, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_occ", 32'(occ), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_s1_out_valid", 32'(bus1.out_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0);
      chk("postrst_out_valid", 32'(bus.out_valid), 0);
    end
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      np.delete();
      prev = S + 1;
      foreach (q[k]) begin
        p = q[k].pos;
        n = (p == S - 1) ? (out_ready ? S : p) : (prev != p + 1 ? p + 1 : p);
        np.push_back(n);
        prev = n;
      end
      eir = !flush && (q.size() == 0 || np[np.size()-1] != 0);
      eov = q.size() != 0 && q[0].pos == S - 1;
      eir1 = !flush && (!mv1 || out_ready);
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(eir));
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(eov));
      chk("rnd_occ", 32'(occ), 32'(q.size()));
      if (eov) chk("rnd_out_data", bus.out_data, q[0].d);
      chk("rnd_s1_in_ready", 32'(bus1.in_ready), 32'(eir1));
      chk("rnd_s1_out_valid", 32'(bus1.out_valid), 32'(mv1));
      chk("rnd_s1_occ", 32'(occ1), 32'(mv1));
      if (mv1) chk("rnd_s1_out_data", bus1.out_data, md1);
      @(posedge clk);
      foreach (q[k]) q[k].pos = np[k];
      while (q.size() != 0 && q[0].pos == S) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && eir) q.push_back('{in_data, 0});
      if (flush) mv1 = 1'b0;
      else if (in_valid && eir1) begin mv1 = 1'b1; md1 = in_data; end
      else if (mv1 && out_ready) mv1 = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
